// File: rtl/gift_ise_seq.sv
// GIFT cipher ISE helper unit: swapmove, lane rotates and an iterated key-schedule step,
// sequenced by a small IDLE/BUSY/DONE controller with a one-deep result holding register.
module gift_ise_seq #(
  parameter int XLEN     = 32,
  parameter int IW       = 5,
  parameter int MAX_ITER = 16
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [IW-1:0]   in_imm,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rd
);

  localparam logic [2:0] OP_SWAPMOVE = 3'd0;
  localparam logic [2:0] OP_KEYUPD   = 3'd1;
  localparam logic [2:0] OP_RORI_N   = 3'd2;
  localparam logic [2:0] OP_RORI_B   = 3'd3;
  localparam logic [2:0] OP_RORI_H   = 3'd4;
  localparam logic [2:0] OP_RORI_W   = 3'd5;

  localparam logic [IW-1:0]   MAX_N   = IW'(MAX_ITER);
  localparam logic [IW-1:0]   CNT_ONE = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0]   CNT_ZERO = {IW{1'b0}};
  localparam logic [XLEN-1:0] ZERO_X  = {XLEN{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [IW-1:0]   cnt_r, cnt_s;
  logic [XLEN-1:0] rs1_r, rs1_s;
  logic [XLEN-1:0] rd_r, rd_s;
  logic            in_ready_r, out_valid_r;
  logic [XLEN-1:0] alu_s;
  logic [XLEN-1:0] step_s;
  logic [IW-1:0]   n_s;

  // Rotate every lw-bit lane right by amt mod lw; lanes never exchange bits.
  function automatic logic [XLEN-1:0] rori_lanes(input logic [XLEN-1:0] x,
                                                 input logic [IW-1:0]   amt,
                                                 input int              lw);
    logic [XLEN-1:0] y;
    int a;
    int base;
    int pos;
    y = ZERO_X;
    a = int'(amt) % lw;
    for (int i = 0; i < XLEN; i++) begin
      base = (i / lw) * lw;
      pos  = i % lw;
      y[i] = x[base + ((pos + a) % lw)];
    end
    return y;
  endfunction

  function automatic logic [XLEN-1:0] swapmove(input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] m,
                                               input logic [IW-1:0]   sh);
    logic [XLEN-1:0] t;
    t = (a ^ (a >> sh)) & m;
    return a ^ t ^ (t << sh);
  endfunction

  // One key-schedule step per 32-bit word: low half rotl 4, high half rotr 2.
  function automatic logic [XLEN-1:0] key_step(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] y;
    logic [15:0]     lo;
    logic [15:0]     hi;
    y = x;
    for (int w = 0; w < XLEN / 32; w++) begin
      lo = x[w*32 +: 16];
      hi = x[w*32+16 +: 16];
      y[w*32 +: 16]    = {lo[11:0], lo[15:12]};
      y[w*32+16 +: 16] = {hi[1:0], hi[15:2]};
    end
    return y;
  endfunction

  assign step_s = key_step(rs1_r);

  // Iteration count saturates at MAX_ITER.
  always_comb begin
    n_s = in_imm;
    if (in_imm > MAX_N) begin
      n_s = MAX_N;
    end else begin
      n_s = in_imm;
    end
  end

  // Single-cycle result for every op, taken straight from the request operands.
  always_comb begin
    alu_s = ZERO_X;
    case (in_op)
      OP_SWAPMOVE: alu_s = swapmove(in_rs1, in_rs2, in_imm);
      OP_KEYUPD:   alu_s = in_rs1;
      OP_RORI_N:   alu_s = rori_lanes(in_rs1, in_imm, 4);
      OP_RORI_B:   alu_s = rori_lanes(in_rs1, in_imm, 8);
      OP_RORI_H:   alu_s = rori_lanes(in_rs1, in_imm, 16);
      OP_RORI_W: begin
        if (XLEN > 32) begin
          alu_s = rori_lanes(in_rs1, in_imm, 32);
        end else begin
          alu_s = ZERO_X;
        end
      end
      default:     alu_s = ZERO_X;
    endcase
  end

  // Next-state and datapath update; rd is held at zero outside DONE.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    rs1_s   = rs1_r;
    rd_s    = rd_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          rs1_s = in_rs1;
          if ((in_op == OP_KEYUPD) && (n_s != CNT_ZERO)) begin
            state_s = BUSY;
            cnt_s   = n_s;
            rd_s    = ZERO_X;
          end else begin
            state_s = DONE;
            cnt_s   = CNT_ZERO;
            rd_s    = alu_s;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == CNT_ONE) begin
          state_s = DONE;
          cnt_s   = CNT_ZERO;
          rd_s    = step_s;
        end else begin
          state_s = BUSY;
          cnt_s   = cnt_r - CNT_ONE;
          rs1_s   = step_s;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
          rs1_s   = ZERO_X;
          rd_s    = ZERO_X;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
        rs1_s   = ZERO_X;
        rd_s    = ZERO_X;
      end
    endcase
  end

  // State and output registers; handshake flags are decoded from the next state.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      rs1_r       <= ZERO_X;
      rd_r        <= ZERO_X;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      rs1_r       <= rs1_s;
      rd_r        <= rd_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_rd    = rd_r;

endmodule

// File: doc/gift_ise_seq.md
GIFT_ISE_SEQ -- requirements
Module: gift_ise_seq

Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath width; legal values 32 and 64 only.
REQ-002 SHALL provide parameter IW, default 5, immediate width; SHALL equal log2(XLEN).
REQ-003 SHALL provide parameter MAX_ITER, default 16, maximum keyupdate iteration count; range 1..2^IW-1.
REQ-004 g_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 g_resetn  input  1  reset; synchronous, active-low.
REQ-006 in_valid  input  1  request valid.
REQ-007 in_ready  output  1  unit can accept a request.
REQ-008 in_op  input  3  operation select, encoding in REQ-014.
REQ-009 in_imm  input  IW  shift, rotate or iteration amount.
REQ-010 in_rs1  input  XLEN  source operand 1.
REQ-011 in_rs2  input  XLEN  source operand 2 (mask for swapmove; ignored otherwise).
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts result; out_rd  output  XLEN  result.

Function
REQ-014 Op encoding SHALL be: 0 swapmove, 1 keyupdate-iterate, 2 rori_n, 3 rori_b, 4 rori_h, 5 rori_w, 6-7 reserved.
REQ-015 swapmove SHALL give t = (rs1 ^ (rs1 >> imm)) & rs2 and rd = rs1 ^ t ^ (t << imm); logical shifts over full XLEN.
REQ-016 rori_n/b/h/w SHALL rotate each 4/8/16/32-bit lane right by imm mod lane width, lanes independent.
REQ-017 rori_w with XLEN=32, and reserved ops, SHALL complete normally with rd = 0.
REQ-018 One keyupdate step SHALL act on each 32-bit word independently: low halfword rotated left 4, high halfword rotated right 2.
REQ-019 keyupdate-iterate SHALL apply N steps, N = min(imm, MAX_ITER); N = 0 SHALL return rs1 unchanged.
REQ-020 FSM states SHALL be IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-021 IDLE + in_valid: operands SHALL be captured. Non-iterative ops and N = 0 SHALL go to DONE next cycle with result registered. N >= 1 SHALL go to BUSY with counter = N.
REQ-022 BUSY SHALL apply one step per cycle and decrement the counter; when counter reaches 1 the step SHALL complete and go to DONE. Latency from accept to out_valid SHALL be N+1 cycles.
REQ-023 DONE SHALL assert out_valid with out_rd stable; out_valid && out_ready SHALL return to IDLE next cycle.
REQ-024 No new request SHALL be accepted in DONE even when out_ready is high; throughput is at most one op per 2 cycles for single-step ops.
REQ-025 in_op, in_imm, in_rs1 and in_rs2 changing while not in IDLE SHALL have no effect on the result.
REQ-026 out_rd SHALL be 0 whenever out_valid is 0.
REQ-027 A held-off consumer (out_ready = 0) SHALL stall indefinitely in DONE without loss or change of the result.

Reset
REQ-028 g_resetn = 0 at a clock edge SHALL force IDLE, counter 0, operand and result registers 0, out_valid 0, and in_ready 1 from the following cycle.
REQ-029 Reset asserted in BUSY or DONE SHALL discard the in-flight operation; no out_valid SHALL follow it.
REQ-030 in_valid during the reset cycle SHALL be ignored.

Verification
REQ-031 XLEN=32, op 0, rs1=0x00000001, rs2=0x00000001, imm=1 -> out_valid 1 cycle after accept, rd=0x00000002.
REQ-032 XLEN=32, op 3, rs1=0x01020304, imm=1 -> rd=0x80018102.
REQ-033 XLEN=32, op 1, rs1=0x00000001, imm=2 -> rd=0x00000100, out_valid 3 cycles after accept; rs1=0x00010000, imm=1 -> rd=0x40000000.
REQ-034 Any op with out_ready held 0 for 10 cycles -> out_valid and out_rd stable and in_ready 0 throughout; release -> IDLE next cycle.
REQ-035 op 1, imm=5, g_resetn pulsed low in the 3rd BUSY cycle -> IDLE next cycle, out_valid never asserted, next request is correct.
REQ-036 XLEN=64, op 5, rs1=0x0000000100000001, imm=1 -> rd=0x8000000080000000; XLEN=32 op 5 -> rd=0.
